mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin read arbiter that shares one BRAM port among NUM_PROC processors.
// A tag pipeline follows each read so its data returns to the right requester. Drain is supported.
module mem_arbiter #(
    parameter int NUM_PROC   = 4,
    parameter int PROC_BITS  = 2,
    parameter int ADDR_WIDTH = 14,
    parameter int RD_LATENCY = 2
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [NUM_PROC-1:0]      req_valid_in,
    input  logic [NUM_PROC*32-1:0]   req_addr_in,
    output logic [NUM_PROC-1:0]      req_ready_out,
    output logic [ADDR_WIDTH-1:0]    mem_addr_out,
    output logic                     mem_en_out,
    input  logic [31:0]              mem_data_in,
    output logic [NUM_PROC-1:0]      resp_valid_out,
    output logic [31:0]              resp_data_out,
    input  logic                     drain_in,
    output logic                     drained_out
);

    typedef enum logic [1:0] {StActive, StDraining, StDrained} state_t;

    state_t                 state;
    logic [PROC_BITS-1:0]   last_grant;
    logic [PROC_BITS-1:0]   issue_tag;
    logic [RD_LATENCY-1:0]  pipe_valid;
    logic [PROC_BITS-1:0]   pipe_tag [RD_LATENCY];

    logic                   found;
    logic                   accept;
    logic [PROC_BITS-1:0]   grant_idx;
    logic                   in_flight;
    int                     idx;

    // Search starts one past the last grant so every requester gets a turn.
    always_comb begin
        found     = 1'b0;
        grant_idx = last_grant;
        idx       = 0;
        for (int k = 1; k <= NUM_PROC; k++) begin
            idx = (int'(last_grant) + k) % NUM_PROC;
            if (!found && req_valid_in[idx]) begin
                found     = 1'b1;
                grant_idx = PROC_BITS'(idx);
            end
        end
        accept        = found && (state == StActive) && !drain_in && !rst_in;
        req_ready_out = '0;
        if (accept) begin
            req_ready_out[grant_idx] = 1'b1;
        end
    end

    assign in_flight = mem_en_out | (|pipe_valid);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            last_grant     <= PROC_BITS'(NUM_PROC - 1);
            mem_en_out     <= 1'b0;
            mem_addr_out   <= '0;
            issue_tag      <= '0;
            pipe_valid     <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_tag[i] <= '0;
            end
            resp_valid_out <= '0;
            resp_data_out  <= '0;
        end else begin
            mem_en_out <= accept;
            if (accept) begin
                last_grant   <= grant_idx;
                issue_tag    <= grant_idx;
                mem_addr_out <= req_addr_in[32*grant_idx +: ADDR_WIDTH];
            end
            // Tag shift register stays aligned with the BRAM read latency.
            pipe_valid[0] <= mem_en_out;
            pipe_tag[0]   <= issue_tag;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_tag[i]   <= pipe_tag[i-1];
            end
            resp_valid_out <= '0;
            if (pipe_valid[RD_LATENCY-1]) begin
                resp_valid_out[pipe_tag[RD_LATENCY-1]] <= 1'b1;
                resp_data_out                          <= mem_data_in;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state       <= StActive;
            drained_out <= 1'b0;
        end else begin
            unique case (state)
                StActive: begin
                    if (drain_in) begin
                        state <= StDraining;
                    end
                end
                StDraining: begin
                    if (!drain_in) begin
                        state <= StActive;
                    end else if (!in_flight) begin
                        state       <= StDrained;
                        drained_out <= 1'b1;
                    end
                end
                StDrained: begin
                    if (!drain_in) begin
                        state       <= StActive;
                        drained_out <= 1'b0;
                    end
                end
                default: begin
                    state       <= StActive;
                    drained_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; a 2-cycle BRAM model returns mem[a] = a*4.
module tb_mem_arbiter;

    logic         clk_in = 1'b0;
    logic         rst_in;
    logic [3:0]   req_valid_in;
    logic [127:0] req_addr_in;
    logic [3:0]   req_ready_out;
    logic [13:0]  mem_addr_out;
    logic         mem_en_out;
    logic [31:0]  mem_data_in;
    logic [3:0]   resp_valid_out;
    logic [31:0]  resp_data_out;
    logic         drain_in;
    logic         drained_out;

    logic [31:0]  bram_r1;
    int           total = 0;
    int           bad   = 0;

    mem_arbiter dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .req_valid_in   (req_valid_in),
        .req_addr_in    (req_addr_in),
        .req_ready_out  (req_ready_out),
        .mem_addr_out   (mem_addr_out),
        .mem_en_out     (mem_en_out),
        .mem_data_in    (mem_data_in),
        .resp_valid_out (resp_valid_out),
        .resp_data_out  (resp_data_out),
        .drain_in       (drain_in),
        .drained_out    (drained_out)
    );

    always #5 clk_in = ~clk_in;

    always_ff @(posedge clk_in) begin
        if (mem_en_out) bram_r1 <= 32'(mem_addr_out) * 32'd4;
        mem_data_in <= bram_r1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        #2;
        rst_in = 1'b0;
    endtask

    initial begin
        rst_in       = 1'b1;
        drain_in     = 1'b0;
        req_valid_in = 4'b1111;
        req_addr_in  = '0;
        bram_r1      = '0;
        mem_data_in  = '0;
        for (int i = 0; i < 4; i++) req_addr_in[32*i +: 32] = 32'hABC0_0100 + 32'(i);
        #3;
        // reset state
        check("rst_ready", 32'(req_ready_out), 32'h0);
        check("rst_en", 32'(mem_en_out), 32'h0);
        check("rst_addr", 32'(mem_addr_out), 32'h0);
        check("rst_rvalid", 32'(resp_valid_out), 32'h0);
        check("rst_rdata", resp_data_out, 32'h0);
        check("rst_drained", 32'(drained_out), 32'h0);
        req_valid_in = 4'b0000;
        step();
        rst_in = 1'b0;
        step();

        // single request: proc 2, addr 0x10
        req_valid_in = 4'b0100;
        req_addr_in[64 +: 32] = 32'h0000_0010;
        #1;
        check("single_ready", 32'(req_ready_out), 32'h4);
        step();
        req_valid_in = 4'b0000;
        check("single_en", 32'(mem_en_out), 32'h1);
        check("single_addr", 32'(mem_addr_out), 32'h10);
        step();
        check("single_en_low", 32'(mem_en_out), 32'h0);
        check("single_addr_hold", 32'(mem_addr_out), 32'h10);
        step();
        check("single_early", 32'(resp_valid_out), 32'h0);
        step();
        check("single_rvalid", 32'(resp_valid_out), 32'h4);
        check("single_rdata", resp_data_out, 32'h40);
        step();
        check("single_rvalid_off", 32'(resp_valid_out), 32'h0);
        check("single_rdata_hold", resp_data_out, 32'h40);
        req_addr_in[64 +: 32] = 32'hABC0_0102;

        // all four valid from reset: grants 0,1,2,3,0,... back-to-back responses
        do_reset();
        step();
        for (int j = 0; j < 12; j++) begin
            req_valid_in = (j < 8) ? 4'b1111 : 4'b0000;
            #1;
            check("rr_ready", 32'(req_ready_out), (j < 8) ? (32'h1 << (j % 4)) : 32'h0);
            if (j >= 1 && j <= 8) begin
                check("rr_addr", 32'(mem_addr_out), 32'h100 + 32'((j - 1) % 4));
            end
            if (j >= 4) begin
                check("rr_rvalid", 32'(resp_valid_out), 32'h1 << ((j - 4) % 4));
                check("rr_rdata", resp_data_out, (32'h100 + 32'((j - 4) % 4)) * 32'd4);
            end
            step();
        end
        req_valid_in = 4'b0000;

        // procs 1 and 3 with last_grant=1: 3,1,3; procs 0/2 never granted
        req_valid_in = 4'b0010;
        #1;
        check("pair_set", 32'(req_ready_out), 32'h2);
        step();
        req_valid_in = 4'b1010;
        #1;
        check("pair_g3", 32'(req_ready_out), 32'h8);
        step();
        #1;
        check("pair_g1", 32'(req_ready_out), 32'h2);
        step();
        #1;
        check("pair_g3b", 32'(req_ready_out), 32'h8);
        step();
        req_valid_in = 4'b0000;
        for (int j = 0; j < 6; j++) step();

        // drain with 3 reads in flight (last_grant=3, so grants 0,1,2)
        req_valid_in = 4'b1111;
        for (int j = 0; j < 9; j++) begin
            drain_in = (j >= 3);
            #1;
            check("drain_ready", 32'(req_ready_out), (j < 3) ? (32'h1 << j) : 32'h0);
            if (j >= 4 && j <= 6) begin
                check("drain_rvalid", 32'(resp_valid_out), 32'h1 << (j - 4));
                check("drain_rdata", resp_data_out, (32'h100 + 32'(j - 4)) * 32'd4);
            end else begin
                check("drain_rquiet", 32'(resp_valid_out), 32'h0);
            end
            check("drain_flag", 32'(drained_out), (j >= 7) ? 32'h1 : 32'h0);
            step();
        end
        drain_in = 1'b0;
        #1;
        check("undrain_ready0", 32'(req_ready_out), 32'h0);
        check("undrain_flag1", 32'(drained_out), 32'h1);
        step();
        check("undrain_flag0", 32'(drained_out), 32'h0);
        check("undrain_ready", 32'(req_ready_out), 32'h8);
        step();
        #1;
        check("pre_rst_ready", 32'(req_ready_out), 32'h1);
        step();

        // reset with 2 reads in flight
        rst_in = 1'b1;
        #1;
        check("arst_ready", 32'(req_ready_out), 32'h0);
        check("arst_en", 32'(mem_en_out), 32'h0);
        check("arst_addr", 32'(mem_addr_out), 32'h0);
        check("arst_rvalid", 32'(resp_valid_out), 32'h0);
        check("arst_rdata", resp_data_out, 32'h0);
        req_valid_in = 4'b0000;
        #2;
        rst_in = 1'b0;
        for (int j = 0; j < 6; j++) begin
            step();
            check("arst_noresp", 32'(resp_valid_out), 32'h0);
        end
        req_valid_in = 4'b1111;
        #1;
        check("arst_first", 32'(req_ready_out), 32'h1);
        step();
        req_valid_in = 4'b0000;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
